// File: rtl/des_dec_key_schedule.sv
// rtl/des_dec_key_schedule.sv - iterative DES key schedule streaming 16 subkeys with on-the-fly rotations
module des_dec_key_schedule #(
   parameter int DECRYPT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:64] key_in,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [1:48] subkey_out,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [4:0]  round_idx,
   output logic        subkey_last
);

   typedef enum logic {IDLE, RUN} state_t;

   // Decryption walks the schedule backwards with right rotations.
   localparam logic rot_left = (DECRYPT == 0);

   state_t      state, state_nxt;
   logic [1:28] c, d, c_nxt, d_nxt;
   logic [1:28] pc1_c, pc1_d;
   logic [4:0]  round_nxt;
   logic [4:0]  next_round;
   logic [4:0]  shift_sel;
   logic        unused_parity;

   // Rotate a 28-bit half by one or two places; the halves never exchange bits.
   function automatic logic [1:28] rot(input logic [1:28] x, input logic left, input logic two);
      if (left)
         rot = two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
      else
         rot = two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
   endfunction

   // Shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1: single steps at 1, 2, 9 and 16.
   function automatic logic two_step(input logic [4:0] r);
      two_step = !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
   endfunction

   assign pc1_c = {key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
                   key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
                   key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
                   key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36]};

   assign pc1_d = {key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
                   key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
                   key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
                   key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]};

   // Parity bits take no part in the schedule.
   assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                            key_in[40], key_in[48], key_in[56], key_in[64]};

   assign next_round = round_idx + 5'd1;
   // Going backwards, round r uses the shift that forward round 18-r would have applied.
   assign shift_sel  = rot_left ? next_round : (5'd18 - next_round);

   // State and C/D registers; reset abandons any stream in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         c         <= '0;
         d         <= '0;
         round_idx <= '0;
      end else begin
         state     <= state_nxt;
         c         <= c_nxt;
         d         <= d_nxt;
         round_idx <= round_nxt;
      end
   end

   // Next-state: load on key handshake, rotate on each subkey handshake.
   always_comb begin
      state_nxt = state;
      c_nxt     = c;
      d_nxt     = d;
      round_nxt = round_idx;
      case (state)
         IDLE: begin
            if (key_valid) begin
               c_nxt     = rot_left ? rot(pc1_c, 1'b1, 1'b0) : pc1_c;
               d_nxt     = rot_left ? rot(pc1_d, 1'b1, 1'b0) : pc1_d;
               round_nxt = 5'd1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (round_idx == 5'd16) begin
                  state_nxt = IDLE;
                  round_nxt = '0;
               end else begin
                  round_nxt = next_round;
                  c_nxt     = rot(c, rot_left, two_step(shift_sel));
                  d_nxt     = rot(d, rot_left, two_step(shift_sel));
               end
            end
         end
      endcase
   end

   assign key_ready    = (state == IDLE);
   assign subkey_valid = (state == RUN);
   assign subkey_last  = subkey_valid && (round_idx == 5'd16);

   // PC-2 written against C (positions 1..28) and D (positions 29..56).
   assign subkey_out = subkey_valid ?
      {c[14], c[17], c[11], c[24], c[1],  c[5],  c[3],  c[28], c[15], c[6],  c[21], c[10],
       c[23], c[19], c[12], c[4],  c[26], c[8],  c[16], c[7],  c[27], c[20], c[13], c[2],
       d[13], d[24], d[3],  d[9],  d[19], d[27], d[2],  d[12], d[23], d[17], d[5],  d[20],
       d[16], d[21], d[11], d[28], d[6],  d[25], d[18], d[14], d[22], d[8],  d[1],  d[4]}
      : '0;

endmodule

// File: tb/tb_des_dec_key_schedule.sv
// tb/tb_des_dec_key_schedule.sv - self-checking bench for des_dec_key_schedule (both build orders)
module tb_des_dec_key_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] key_in;
   logic        key_valid;
   logic        subkey_ready;

   logic        kr_d, sv_d, sl_d, kr_e, sv_e, sl_e;
   logic [47:0] sk_d, sk_e;
   logic [4:0]  ri_d, ri_e;

   always #5 clk = ~clk;

   des_dec_key_schedule #(.DECRYPT(1)) dut_dec (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(kr_d),
      .subkey_out(sk_d), .subkey_valid(sv_d), .subkey_ready(subkey_ready),
      .round_idx(ri_d), .subkey_last(sl_d));

   des_dec_key_schedule #(.DECRYPT(0)) dut_enc (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(kr_e),
      .subkey_out(sk_e), .subkey_valid(sv_e), .subkey_ready(subkey_ready),
      .round_idx(ri_e), .subkey_last(sl_e));

   int checks   = 0;
   int failures = 0;
   string cur_tag = "";

   int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   int sh_t[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   logic [47:0] ref_k[1:16];

   typedef struct {
      logic [63:0] key;
      logic [47:0] first;
      logic [47:0] last;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s %s actual=%0h required=%0h", cur_tag, name, act, exp);
      end
   endtask

   // Textbook schedule: Kn = PC2(C0D0 rotated left by the running shift total).
   task automatic model(input logic [63:0] key);
      logic        c0[28];
      logic        d0[28];
      logic        cd[56];
      logic [47:0] k;
      int          tot;
      for (int i = 0; i < 28; i++) begin
         c0[i] = key[64 - pc1_t[i]];
         d0[i] = key[64 - pc1_t[28 + i]];
      end
      tot = 0;
      for (int n = 1; n <= 16; n++) begin
         tot += sh_t[n - 1];
         for (int i = 0; i < 28; i++) begin
            cd[i]      = c0[(i + tot) % 28];
            cd[28 + i] = d0[(i + tot) % 28];
         end
         for (int j = 0; j < 48; j++) k[47 - j] = cd[pc2_t[j] - 1];
         ref_k[n] = k;
      end
   endtask

   task automatic run_stream(input logic [63:0] key, input logic [47:0] exp_first,
                             input logic [47:0] exp_last, input bit bp,
                             input int inject_round, input int reset_round);
      int t, hs, cyc, low_run;
      t = 0;
      while (!(kr_d && kr_e) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++;
         failures++;
         $display("FAIL %s key_ready_wait timed out", cur_tag);
         return;
      end
      key_in       = key;
      key_valid    = 1'b1;
      subkey_ready = 1'b0;
      @(negedge clk);
      hs = 0;
      cyc = 0;
      low_run = 0;
      while (hs < 16 && cyc < 300) begin
         key_valid = 1'b0;
         key_in    = key;
         chk("dec_valid", sv_d, 1);
         chk("dec_round", ri_d, hs + 1);
         chk("dec_subkey", sk_d, ref_k[16 - hs]);
         chk("dec_last", sl_d, (hs == 15));
         chk("dec_key_ready_run", kr_d, 0);
         chk("enc_valid", sv_e, 1);
         chk("enc_round", ri_e, hs + 1);
         chk("enc_subkey", sk_e, ref_k[hs + 1]);
         chk("enc_last", sl_e, (hs == 15));
         chk("enc_key_ready_run", kr_e, 0);
         if (hs == 0) begin
            chk("dec_first_vec", sk_d, exp_first);
            chk("enc_first_vec", sk_e, exp_last);
         end
         if (hs == 15) begin
            chk("dec_last_vec", sk_d, exp_last);
            chk("enc_last_vec", sk_e, exp_first);
         end
         if (reset_round == hs + 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            subkey_ready = 1'b0;
            chk("rst_dec_valid", sv_d, 0);
            chk("rst_dec_key_ready", kr_d, 1);
            chk("rst_dec_round", ri_d, 0);
            chk("rst_dec_subkey", sk_d, 0);
            chk("rst_enc_valid", sv_e, 0);
            chk("rst_enc_key_ready", kr_e, 1);
            return;
         end
         if (inject_round == hs + 1) begin
            key_valid = 1'b1;
            key_in    = '1;
         end
         if (bp) begin
            if (low_run >= 5) subkey_ready = 1'b1;
            else subkey_ready = 1'($urandom_range(0, 1));
            low_run = subkey_ready ? 0 : low_run + 1;
         end else begin
            subkey_ready = 1'b1;
         end
         if (subkey_ready) hs++;
         @(negedge clk);
         cyc++;
      end
      key_valid    = 1'b0;
      subkey_ready = 1'b0;
      if (hs < 16) begin
         checks++;
         failures++;
         $display("FAIL %s handshake_count actual=%0d required=16", cur_tag, hs);
         return;
      end
      chk("post_dec_valid", sv_d, 0);
      chk("post_dec_key_ready", kr_d, 1);
      chk("post_enc_valid", sv_e, 0);
      chk("post_enc_key_ready", kr_e, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rk;
      rst          = 1'b1;
      key_in       = '0;
      key_valid    = 1'b0;
      subkey_ready = 1'b0;
      repeat (3) @(negedge clk);
      cur_tag = "reset";
      chk("key_ready", kr_d, 1);
      chk("subkey_valid", sv_d, 0);
      chk("subkey_last", sl_d, 0);
      chk("round_idx", ri_d, 0);
      chk("subkey_out", sk_d, 0);
      chk("enc_key_ready", kr_e, 1);
      rst = 1'b0;
      @(negedge clk);

      vecs[0] = '{64'h133457799BBCDFF1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
      vecs[1] = '{64'h123457799ABCDFF0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
      vecs[2] = '{64'h0000000000000000, 48'h000000000000, 48'h000000000000};
      vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
      for (int i = 0; i < 4; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         model(vecs[i].key);
         run_stream(vecs[i].key, vecs[i].first, vecs[i].last, 1'b0, 0, 0);
      end

      cur_tag = "backpressure";
      model(vecs[0].key);
      run_stream(vecs[0].key, vecs[0].first, vecs[0].last, 1'b1, 0, 0);

      cur_tag = "ignored_load";
      run_stream(vecs[0].key, vecs[0].first, vecs[0].last, 1'b0, 5, 0);

      cur_tag = "reset_mid";
      run_stream(vecs[0].key, vecs[0].first, vecs[0].last, 1'b0, 0, 9);
      cur_tag = "after_reset_zero";
      model(64'h0);
      run_stream(64'h0, 48'h0, 48'h0, 1'b0, 0, 0);

      for (int r = 0; r < 6; r++) begin
         cur_tag = $sformatf("random%0d", r);
         rk = {$urandom, $urandom};
         model(rk);
         run_stream(rk, ref_k[16], ref_k[1], 1'b1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
